dma_wr_arb: RTL and testbench
=============================

Name: dma_wr_arb

Overview:
- Round-robin arbiter and sequencer that shares the single DataMover S2MM write channel of bd_wrap among NUM_REQ requesters.
- Accepts one write command (addr, byte length) per requester and drives wstart/waddr/wdata_len when the channel is ready.
- Streams the granted requester's beats onto wdata_vld/wdata, counts beats to completion, then rotates priority.
- Sits between the user datapaths and bd_wrap in the clk_250m domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 32, byte address width
- LEN_WIDTH, 16, byte length width
- DATA_WIDTH, 64, stream width; BYTES = DATA_WIDTH/8

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- req_vld  in  NUM_REQ  per-requester command pending; level, held until req_ack
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened start addresses, slice i = requester i
- req_len  in  NUM_REQ*LEN_WIDTH  flattened byte lengths
- req_ack  out  NUM_REQ  one-hot 1-cycle pulse: command accepted or rejected
- req_err  out  NUM_REQ  one-hot pulse with req_ack when req_len==0 (rejected)
- req_data_en  out  NUM_REQ  one-hot; granted requester may present data
- req_data_vld  in  NUM_REQ  per-requester beat valid
- req_data  in  NUM_REQ*DATA_WIDTH  flattened beat data
- req_done  out  NUM_REQ  one-hot 1-cycle pulse when the last beat is forwarded
- wstart  out  1  command strobe to bd_wrap
- wready  in  1  bd_wrap can accept a new command
- waddr  out  ADDR_WIDTH  command address
- wdata_len  out  LEN_WIDTH  command byte length
- wdata_vld  out  1  beat valid to bd_wrap
- wdata  out  DATA_WIDTH  beat data to bd_wrap
- busy  out  1  high in any state other than IDLE
- cur_sel  out  $clog2(NUM_REQ)  index of the current/last grant

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr=0; beat counter 0.
- Beats = ceil(len/BYTES), computed as (len + BYTES-1) >> log2(BYTES) at LEN_WIDTH+1 bits, so len=0xFFFF does not overflow.
- IDLE:
  - When wready=1 and |req_vld, grant the first set req_vld at or after rr_ptr (wrapping), latch addr/len/sel, go to CMD.
  - If the winner's len==0, pulse req_ack+req_err for one cycle, set rr_ptr=sel+1 mod NUM_REQ, and stay in IDLE. No wstart is issued.
  - When wready=0, no grant is made, even with requests pending.
- CMD (1 cycle):
  - wstart=1; waddr/wdata_len = latched values.
  - req_ack[sel]=1; go to DATA.
  - waddr/wdata_len stay stable until the return to IDLE.
- DATA:
  - req_data_en[sel]=1.
  - Each cycle with req_data_vld[sel]=1, register the beat: wdata_vld=1 and wdata=req_data[sel] one cycle later (latency 1). The beat counter increments.
  - req_data_vld from non-granted requesters is ignored.
  - Gaps (vld=0) are allowed; wdata_vld=0 during a gap.
  - On acceptance of the final beat: req_data_en drops the next cycle, req_done[sel] pulses aligned with the last wdata_vld, and the state goes to DRAIN.
- DRAIN:
  - Wait for wready=1, meaning the DataMover has finished.
  - Then set rr_ptr=sel+1 mod NUM_REQ and go to IDLE. Earliest re-grant is the following cycle.
- Simultaneous events:
  - Requests that arrive during CMD/DATA/DRAIN wait their turn.
  - A requester deasserting req_vld before ack loses its claim without error.
- Reset mid-transfer: immediate return to IDLE with all outputs 0. A partial transfer is abandoned; recovery of the DataMover is the system's responsibility.
- No more than one outstanding command at any time.

Decomposition:
- Shared package dma_pkg holds:
  - state enum (IDLE, CMD, DATA, DRAIN)
  - the BYTES/beat-count function
  - a clog2 helper constant
- One natural sub-module: rr_arb (parameterised NUM_REQ round-robin priority picker, combinational, req + ptr -> one-hot grant and index).
- Counter, FSM and mux stay in dma_wr_arb.

Test Plan:
- Single request: req0 addr=0x1000 len=64, wready=1, data every cycle. Required response:
  - wstart one pulse with waddr=0x1000, wdata_len=64
  - exactly 8 wdata_vld beats in order, req_done[0] on the 8th beat
  - busy=0 after wready
- Round-robin: req0..req3 all valid, len=8 each. Grant order is 0,1,2,3. After that, a re-asserted req0 together with req2 is granted 0, then 2, from rr_ptr=0.
- Partial beat and gaps: len=20, BYTES=8 -> 3 beats. Insert vld gaps of 2 cycles. Required response: exactly 3 wdata_vld pulses, and data is unchanged.
- Backpressure: wready=0 with req1 pending -> no wstart for 10 cycles. Raising wready -> wstart on the following cycle.
- Zero length: req2 len=0 -> req_ack[2]+req_err[2] pulse, no wstart, and the next grant goes to req3 if pending.
- Reset mid-DATA: assert rst after beat 3 of 8 -> all outputs 0 immediately. The next request is granted from rr_ptr=0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and helpers for the DataMover write arbiter.
// State encoding, beat-count math and index-width helper.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DRAIN
  } state_e;

  localparam int MAX_LEN_W = 32;

  function automatic int unsigned clog2_min1(
    input int unsigned n
  );
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One extra bit so an all-ones length rounds up without wrapping.
  function automatic logic [MAX_LEN_W:0] beat_count(
    input logic [MAX_LEN_W-1:0] len,
    input int unsigned          blog
  );
    logic [MAX_LEN_W:0] bias;
    bias = ((MAX_LEN_W+1)'(1) << blog) - (MAX_LEN_W+1)'(1);
    return ({1'b0, len} + bias) >> blog;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin priority picker: first set request at or after ptr.
// Purely combinational; ptr is always below NUM_REQ.
module rr_arb
  import dma_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int SEL_W = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  localparam logic [SEL_W:0] N_W = (SEL_W+1)'(NUM_REQ);

  always_comb begin
    logic [SEL_W:0] k;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = {1'b0, ptr} + (SEL_W+1)'(i);
      if (k >= N_W) k = k - N_W;
      if (!any && req[k[SEL_W-1:0]]) begin
        any = 1'b1;
        gnt[k[SEL_W-1:0]] = 1'b1;
        idx = k[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dma_wr_arb.sv
// Shares the single S2MM write channel among NUM_REQ requesters:
// round-robin command grant, one-cycle beat forwarding, drain.
module dma_wr_arb
  import dma_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            req_err,
  output logic [NUM_REQ-1:0]            req_data_en,
  input  logic [NUM_REQ-1:0]            req_data_vld,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          wstart,
  input  logic                          wready,
  output logic [ADDR_WIDTH-1:0]         waddr,
  output logic [LEN_WIDTH-1:0]          wdata_len,
  output logic                          wdata_vld,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    cur_sel
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BLOG  = $clog2(BYTES);
  localparam int SEL_W = clog2_min1(NUM_REQ);
  localparam int CNT_W = LEN_WIDTH + 1;

  state_e               state;
  logic [SEL_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]   sel_oh;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [MAX_LEN_W:0]   beats_tot;
  logic                 last_beat;

  logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
  logic [LEN_WIDTH-1:0]  len_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_a [NUM_REQ];

  logic [NUM_REQ-1:0]    g_oh;
  logic [SEL_W-1:0]      g_idx;
  logic                  g_any;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [LEN_WIDTH-1:0]  g_len;
  logic                  beat_vld;
  logic [DATA_WIDTH-1:0] beat;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_a[g]  = req_len[g*LEN_WIDTH +: LEN_WIDTH];
    assign data_a[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arb (
    .req (req_vld),
    .ptr (rr_ptr),
    .gnt (g_oh),
    .idx (g_idx),
    .any (g_any)
  );

  assign g_addr   = addr_a[g_idx];
  assign g_len    = len_a[g_idx];
  assign beat_vld = req_data_vld[cur_sel];
  assign beat     = data_a[cur_sel];

  assign cnt_nxt   = cnt_q + CNT_W'(1);
  assign beats_tot = beat_count(MAX_LEN_W'(wdata_len), BLOG);
  assign last_beat = ((MAX_LEN_W+1)'(cnt_nxt) == beats_tot);

  function automatic logic [SEL_W-1:0] nxt_ptr(
    input logic [SEL_W-1:0] s
  );
    return (s == SEL_W'(NUM_REQ-1)) ? '0 : s + SEL_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      sel_oh      <= '0;
      cnt_q       <= '0;
      req_ack     <= '0;
      req_err     <= '0;
      req_data_en <= '0;
      req_done    <= '0;
      wstart      <= 1'b0;
      waddr       <= '0;
      wdata_len   <= '0;
      wdata_vld   <= 1'b0;
      wdata       <= '0;
      busy        <= 1'b0;
      cur_sel     <= '0;
    end else begin
      wstart    <= 1'b0;
      req_ack   <= '0;
      req_err   <= '0;
      req_done  <= '0;
      wdata_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          // Hold off while an ack is visible so a requester
          // that drops req_vld on that edge is not re-granted.
          if (wready && g_any && !(|req_ack)) begin
            cur_sel <= g_idx;
            sel_oh  <= g_oh;
            req_ack <= g_oh;
            if (g_len == '0) begin
              req_err <= g_oh;
              rr_ptr  <= nxt_ptr(g_idx);
            end else begin
              wstart    <= 1'b1;
              waddr     <= g_addr;
              wdata_len <= g_len;
              cnt_q     <= '0;
              busy      <= 1'b1;
              state     <= CMD;
            end
          end
        end
        CMD: begin
          req_data_en <= sel_oh;
          state       <= DATA;
        end
        DATA: begin
          if (beat_vld) begin
            wdata_vld <= 1'b1;
            wdata     <= beat;
            cnt_q     <= cnt_nxt;
            if (last_beat) begin
              req_done    <= sel_oh;
              req_data_en <= '0;
              state       <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (wready) begin
            rr_ptr <= nxt_ptr(cur_sel);
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_wr_arb.sv
// Self-checking bench for dma_wr_arb: vector table, hand
// sequences and randomized traffic against a grant-order model.
module tb_dma_wr_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int DW = 64;
  localparam int BY = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    req_ack;
  logic [N-1:0]    req_err;
  logic [N-1:0]    req_data_en;
  logic [N-1:0]    req_data_vld;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_done;
  logic            wstart;
  logic            wready;
  logic [AW-1:0]   waddr;
  logic [LW-1:0]   wdata_len;
  logic            wdata_vld;
  logic [DW-1:0]   wdata;
  logic            busy;
  logic [1:0]      cur_sel;

  always #2 clk = ~clk;

  dma_wr_arb #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_vld      (req_vld),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .req_ack      (req_ack),
    .req_err      (req_err),
    .req_data_en  (req_data_en),
    .req_data_vld (req_data_vld),
    .req_data     (req_data),
    .req_done     (req_done),
    .wstart       (wstart),
    .wready       (wready),
    .waddr        (waddr),
    .wdata_len    (wdata_len),
    .wdata_vld    (wdata_vld),
    .wdata        (wdata),
    .busy         (busy),
    .cur_sel      (cur_sel)
  );

  typedef struct {
    logic [3:0]  mask;
    int          l0, l1, l2, l3;
    int          hold;
    int          gap;
    logic [31:0] code;
    int          beats;
  } vec_t;

  vec_t tbl[8];

  int checks = 0;
  int failures = 0;

  logic [N-1:0]  s_mask;
  int            s_len[N];
  logic [AW-1:0] s_addr[N];
  int            mptr;

  logic [3:0]    obs_ack[$];
  logic [47:0]   obs_cmd[$];
  logic [64:0]   obs_beat[$];
  logic [31:0]   last_code;
  int            last_beats;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i, input int b);
    return {8'(8'hA0 + i), 24'(b), s_addr[i]};
  endfunction

  function automatic logic any_out();
    return |{req_ack, req_err, req_data_en, req_done, wstart,
             waddr, wdata_len, wdata_vld, wdata, busy, cur_sel};
  endfunction

  task automatic run_scen(input int hold, input int gmode,
                          input bit noise, input int abort_beats);
    int          exp_k[$];
    logic [N-1:0] pend;
    int          mp, k, seen, orphan, hold_bad, nb, bad, cyc;
    int          bcnt[N];
    int          gap[N];
    bit          pres[N];
    bit          fin;
    logic [47:0] exp_cmd[$];
    logic [64:0] exp_beat[$];
    logic [31:0] ecode;
    pend = s_mask;
    mp = mptr;
    while (pend != 0) begin
      for (int i = 0; i < N; i++) begin
        k = (mp + i) % N;
        if (pend[k]) begin
          exp_k.push_back(k);
          pend[k] = 1'b0;
          mp = (k + 1) % N;
          break;
        end
      end
    end
    obs_ack.delete();
    obs_cmd.delete();
    obs_beat.delete();
    seen = 0; orphan = 0; hold_bad = 0; fin = 1'b0;
    for (int i = 0; i < N; i++) begin
      bcnt[i] = 0; gap[i] = 0; pres[i] = 1'b0;
      req_addr[i*AW +: AW] = s_addr[i];
      req_len[i*LW +: LW] = LW'(s_len[i]);
    end
    wready = (hold == 0);
    req_vld = s_mask;
    for (cyc = 0; cyc < 20000 && !fin; cyc++) begin
      @(negedge clk);
      if (req_ack != 0)
        obs_ack.push_back(4'($clog2(req_ack) + 1) |
                          ((req_err != 0) ? 4'h8 : 4'h0));
      if (wstart) obs_cmd.push_back({waddr, wdata_len});
      if (wdata_vld) begin
        obs_beat.push_back({req_done != 0, wdata});
        seen++;
      end else if (req_done != 0) orphan++;
      if (hold > 0 && cyc < hold && (wstart || req_ack != 0))
        hold_bad++;
      if (hold > 0 && cyc == hold)
        chk("bp_release", {wstart, |req_ack},
            {s_len[exp_k[0]] != 0, 1'b1});
      if (hold > 0 && cyc == hold - 1) wready = 1'b1;
      if (abort_beats > 0 && seen == abort_beats) begin
        rst = 1'b1;
        #1;
        chk("reset_mid_data", any_out(), 0);
        req_vld = '0;
        req_data_vld = '0;
        @(negedge clk);
        rst = 1'b0;
        mptr = 0;
        wready = 1'b1;
        return;
      end
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) req_vld[i] = 1'b0;
        if (pres[i]) bcnt[i]++;
        pres[i] = 1'b0;
        if (req_data_en[i]) begin
          if (gap[i] > 0) begin
            gap[i]--;
            req_data_vld[i] = 1'b0;
          end else if (gmode == 2 && $urandom_range(0, 99) < 30) begin
            req_data_vld[i] = 1'b0;
          end else begin
            req_data_vld[i] = 1'b1;
            req_data[i*DW +: DW] = pat(i, bcnt[i]);
            pres[i] = 1'b1;
            if (gmode == 1) gap[i] = 2;
          end
        end else begin
          req_data_vld[i] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          req_data[i*DW +: DW] = {$urandom, $urandom};
        end
      end
      fin = (req_vld == 0) && !busy && (obs_ack.size() == exp_k.size());
    end
    req_data_vld = '0;
    chk("timeout", fin, 1);
    mptr = mp;
    ecode = '0;
    last_code = '0;
    foreach (exp_k[n]) begin
      ecode |= 32'((exp_k[n] + 1) | ((s_len[exp_k[n]] == 0) ? 8 : 0))
               << (4 * n);
      if (s_len[exp_k[n]] != 0) begin
        exp_cmd.push_back({s_addr[exp_k[n]], LW'(s_len[exp_k[n]])});
        nb = (s_len[exp_k[n]] + BY - 1) / BY;
        for (int j = 0; j < nb; j++)
          exp_beat.push_back({j == nb - 1, pat(exp_k[n], j)});
      end
    end
    foreach (obs_ack[n]) if (n < 8) last_code |= 32'(obs_ack[n]) << (4 * n);
    last_beats = obs_beat.size();
    chk("ack_order", last_code, ecode);
    chk("cmd_count", obs_cmd.size(), exp_cmd.size());
    bad = 0;
    foreach (exp_cmd[n])
      if (n >= obs_cmd.size() || obs_cmd[n] !== exp_cmd[n]) bad++;
    chk("cmd_fields", bad, 0);
    chk("beat_count", obs_beat.size(), exp_beat.size());
    bad = 0;
    foreach (exp_beat[n])
      if (n >= obs_beat.size() || obs_beat[n] !== exp_beat[n]) bad++;
    chk("beat_data_done", bad, 0);
    chk("orphan_done", orphan, 0);
    if (hold > 0) chk("bp_no_wstart", hold_bad, 0);
    chk("busy_end", busy, 0);
  endtask

  task automatic load(input logic [3:0] m, input int a, input int b,
                      input int c, input int d);
    s_mask = m;
    s_len[0] = a; s_len[1] = b; s_len[2] = c; s_len[3] = d;
    for (int i = 0; i < N; i++) s_addr[i] = 32'h1000 + 32'(i) * 32'h100;
  endtask

  initial begin
    tbl[0] = '{4'hF, 8, 8, 8, 8, 0, 0, 32'h4321, 4};
    tbl[1] = '{4'h5, 8, 0, 8, 0, 0, 0, 32'h31, 2};
    tbl[2] = '{4'h1, 64, 0, 0, 0, 0, 0, 32'h1, 8};
    tbl[3] = '{4'h2, 0, 20, 0, 0, 0, 1, 32'h2, 3};
    tbl[4] = '{4'h2, 0, 16, 0, 0, 10, 0, 32'h2, 2};
    tbl[5] = '{4'hC, 0, 0, 0, 8, 0, 0, 32'h4B, 1};
    tbl[6] = '{4'h2, 0, 65535, 0, 0, 0, 0, 32'h2, 8192};
    tbl[7] = '{4'h3, 9, 1, 0, 0, 0, 0, 32'h21, 3};

    rst = 1'b1;
    wready = 1'b0;
    req_vld = '0;
    req_addr = '0;
    req_len = '0;
    req_data_vld = '0;
    req_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", any_out(), 0);
    rst = 1'b0;
    mptr = 0;
    wready = 1'b1;
    @(negedge clk);

    for (int e = 0; e < 8; e++) begin
      load(tbl[e].mask, tbl[e].l0, tbl[e].l1, tbl[e].l2, tbl[e].l3);
      run_scen(tbl[e].hold, tbl[e].gap, 1'b0, 0);
      chk($sformatf("tbl%0d_order", e), last_code, tbl[e].code);
      chk($sformatf("tbl%0d_beats", e), last_beats, tbl[e].beats);
    end

    load(4'h4, 0, 0, 8, 0);
    run_scen(0, 0, 1'b0, 0);
    load(4'h8, 0, 0, 0, 64);
    run_scen(0, 0, 1'b0, 3);
    load(4'h9, 8, 0, 0, 8);
    run_scen(0, 0, 1'b0, 0);
    chk("post_reset_order", last_code, 32'h41);

    for (int r = 0; r < 40; r++) begin
      s_mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        s_len[i] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 80);
        s_addr[i] = $urandom;
      end
      run_scen($urandom_range(0, 3), 2, 1'b1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
